// File: rtl/ffe_adapt_pkg.sv
// Shared types and helpers for the FFE adaptation sequencer.
// State encoding and a saturating magnitude function for signed errors.
package ffe_adapt_pkg;

  localparam logic [1:0] ST_IDLE_C  = 2'd0;
  localparam logic [1:0] ST_FILL_C  = 2'd1;
  localparam logic [1:0] ST_ACQ_C   = 2'd2;
  localparam logic [1:0] ST_TRACK_C = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_C,
    ST_FILL  = ST_FILL_C,
    ST_ACQ   = ST_ACQ_C,
    ST_TRACK = ST_TRACK_C
  } state_e;

  // |e| for an nb-bit signed value carried sign-extended in 32 bits;
  // the most negative code folds onto the largest positive one.
  function automatic logic [31:0] abs_sat(
    input logic signed [31:0] e,
    input int unsigned        nb
  );
    logic signed [31:0] lo;
    logic [31:0]        hi;
    hi = (32'd1 << (nb - 1)) - 32'd1;
    lo = -$signed(hi) - 32'sd1;
    if (e == lo)
      return hi;
    if (e < 0)
      return 32'(-e);
    return 32'(e);
  endfunction

endpackage

// File: rtl/ffe_adapt_ctrl_err_win_acc.sv
// Windowed sum of |CMA error|: accumulates over 2^WIN_LOG2 samples,
// exposes the closing sum combinationally and registers the last metric.
module err_win_acc
  import ffe_adapt_pkg::*;
#(
  parameter  int NB_ERR   = 8,
  parameter  int WIN_LOG2 = 6,
  localparam int NB_ACC   = NB_ERR + WIN_LOG2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [NB_ERR-1:0] err_i,
  output logic [NB_ACC-1:0]        sum_o,
  output logic                     done_o,
  output logic [NB_ACC-1:0]        metric_o
);

  logic [NB_ACC-1:0]   acc_q, acc_d;
  logic [NB_ACC-1:0]   metric_q, metric_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [31:0]         mag_w;

  assign mag_w  = abs_sat(32'(err_i), NB_ERR);
  assign sum_o  = acc_q + NB_ACC'(mag_w);
  assign done_o = en_i && (cnt_q == '1);

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    metric_d = metric_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
      if (done_o) begin
        acc_d    = '0;
        metric_d = sum_o;
      end else begin
        acc_d = sum_o;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      metric_q <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      metric_q <= metric_d;
    end
  end

  assign metric_o = metric_q;

endmodule

// File: rtl/ffe_adapt_ctrl.sv
// Adaptation sequencer for the FFE + CMA equalizer: fill, annealed
// acquisition, lock detection and decision-directed tracking.
module ffe_adapt_ctrl
  import ffe_adapt_pkg::*;
#(
  parameter  int               FIR_LEN    = 21,
  parameter  int               PIPE_LAT   = 2,
  parameter  int               NB_ERR     = 8,
  parameter  int               NB_MU      = 16,
  parameter  logic [NB_MU-1:0] MU_INIT    = 16'h4000,
  parameter  logic [NB_MU-1:0] MU_MIN     = 16'h0400,
  parameter  logic [NB_MU-1:0] MU_TRACK   = 16'h0200,
  parameter  int               UPD_DEC    = 1,
  parameter  int               WIN_LOG2   = 6,
  parameter  int               LOCK_CNT   = 4,
  parameter  int               ANNEAL_WIN = 8,
  localparam int               NB_ACC     = NB_ERR + WIN_LOG2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_freeze,
  input  logic                     i_valid,
  input  logic signed [NB_ERR-1:0] i_cma_error,
  input  logic [NB_ACC-1:0]        i_lock_thr,
  input  logic [NB_ACC-1:0]        i_unlock_thr,
  output logic                     o_fir_en,
  output logic                     o_update_en,
  output logic [NB_MU-1:0]         o_mu,
  output logic                     o_dd_mode,
  output logic                     o_locked,
  output logic [1:0]               o_state,
  output logic [NB_ACC-1:0]        o_win_metric
);

  localparam int FILL_N = FIR_LEN + PIPE_LAT;
  localparam int FW     = $clog2(FILL_N + 1);
  localparam int CW     = 8;

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    dec_q, dec_d;
  logic [CW-1:0]    lock_q, lock_d;
  logic [CW-1:0]    ann_q, ann_d;
  logic [NB_MU-1:0] mu_q, mu_d;
  logic             upd_q, upd_d;
  logic             dd_q, dd_d;
  logic             lk_q, lk_d;
  logic             fir_q, fir_d;

  logic              active_w;
  logic              acc_en_w;
  logic              win_end_w;
  logic [NB_ACC-1:0] win_sum_w;
  logic [CW-1:0]     lock_nx_w;
  logic [NB_MU-1:0]  mu_half_w;

  assign active_w  = (state_q == ST_ACQ) || (state_q == ST_TRACK);
  assign acc_en_w  = i_valid && active_w && !i_stop;
  assign mu_half_w = mu_q >> 1;
  assign lock_nx_w = (win_sum_w < i_lock_thr) ? lock_q + 1'b1 : '0;

  err_win_acc #(
    .NB_ERR   (NB_ERR),
    .WIN_LOG2 (WIN_LOG2)
  ) u_err_win_acc (
    .clk_i    (i_clock),
    .rst_i    (i_reset),
    .clr_i    (i_stop),
    .en_i     (acc_en_w),
    .err_i    (i_cma_error),
    .sum_o    (win_sum_w),
    .done_o   (win_end_w),
    .metric_o (o_win_metric)
  );

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    dec_d   = dec_q;
    lock_d  = lock_q;
    ann_d   = ann_q;
    mu_d    = mu_q;
    upd_d   = 1'b0;
    dd_d    = dd_q;
    lk_d    = lk_q;
    if (i_stop) begin
      state_d = ST_IDLE;
      fill_d  = '0;
      dec_d   = '0;
      lock_d  = '0;
      ann_d   = '0;
      mu_d    = '0;
      dd_d    = 1'b0;
      lk_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start)
            state_d = ST_FILL;
        end
        ST_FILL: begin
          if (i_valid) begin
            if (fill_q == FW'(FILL_N - 1)) begin
              state_d = ST_ACQ;
              fill_d  = '0;
              mu_d    = MU_INIT;
            end else begin
              fill_d = fill_q + 1'b1;
            end
          end
        end
        ST_ACQ, ST_TRACK: begin
          if (i_valid) begin
            if (dec_q == CW'(UPD_DEC - 1)) begin
              dec_d = '0;
              upd_d = !i_freeze;
            end else begin
              dec_d = dec_q + 1'b1;
            end
          end
          if (win_end_w && state_q == ST_ACQ) begin
            lock_d = lock_nx_w;
            if (lock_nx_w == CW'(LOCK_CNT)) begin
              state_d = ST_TRACK;
              mu_d    = MU_TRACK;
              lk_d    = 1'b1;
              dd_d    = 1'b1;
              lock_d  = '0;
              ann_d   = '0;
            end else if (!i_freeze) begin
              // Halve mu once per ANNEAL_WIN unfrozen windows, floored.
              if (ann_q == CW'(ANNEAL_WIN - 1)) begin
                ann_d = '0;
                mu_d  = (mu_half_w < MU_MIN) ? MU_MIN : mu_half_w;
              end else begin
                ann_d = ann_q + 1'b1;
              end
            end
          end else if (win_end_w && win_sum_w > i_unlock_thr) begin
            state_d = ST_ACQ;
            mu_d    = MU_INIT;
            lk_d    = 1'b0;
            dd_d    = 1'b0;
            lock_d  = '0;
            ann_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    fir_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      dec_q   <= '0;
      lock_q  <= '0;
      ann_q   <= '0;
      mu_q    <= '0;
      upd_q   <= 1'b0;
      dd_q    <= 1'b0;
      lk_q    <= 1'b0;
      fir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      dec_q   <= dec_d;
      lock_q  <= lock_d;
      ann_q   <= ann_d;
      mu_q    <= mu_d;
      upd_q   <= upd_d;
      dd_q    <= dd_d;
      lk_q    <= lk_d;
      fir_q   <= fir_d;
    end
  end

  assign o_fir_en    = fir_q;
  assign o_update_en = upd_q;
  assign o_mu        = mu_q;
  assign o_dd_mode   = dd_q;
  assign o_locked    = lk_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_ffe_adapt_ctrl.sv
// Scoreboard bench for ffe_adapt_ctrl: a sample-level reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_ffe_adapt_ctrl;

  localparam int FILL_N     = 23;
  localparam int WIN_N      = 64;
  localparam int LOCK_CNT   = 4;
  localparam int ANNEAL_WIN = 8;
  localparam int UPD_DEC    = 1;
  localparam int MU_INIT    = 'h4000;
  localparam int MU_MIN     = 'h0400;
  localparam int MU_TRACK   = 'h0200;

  typedef struct packed {
    logic        fir;
    logic        upd;
    logic [15:0] mu;
    logic        dd;
    logic        lk;
    logic [1:0]  st;
    logic [13:0] met;
  } obs_t;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_start = 1'b0;
  logic              i_stop = 1'b0;
  logic              i_freeze = 1'b0;
  logic              i_valid = 1'b0;
  logic signed [7:0] i_cma_error = '0;
  logic [13:0]       i_lock_thr = 14'd100;
  logic [13:0]       i_unlock_thr = 14'd2000;
  logic              o_fir_en;
  logic              o_update_en;
  logic [15:0]       o_mu;
  logic              o_dd_mode;
  logic              o_locked;
  logic [1:0]        o_state;
  logic [13:0]       o_win_metric;

  int n_checks = 0;
  int n_errors = 0;
  obs_t exp_q[$];

  int m_st, m_fill, m_dec, m_lock, m_ann, m_mu, m_sum, m_n, m_met;
  bit m_upd, m_dd, m_lk;

  ffe_adapt_ctrl dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_freeze     (i_freeze),
    .i_valid      (i_valid),
    .i_cma_error  (i_cma_error),
    .i_lock_thr   (i_lock_thr),
    .i_unlock_thr (i_unlock_thr),
    .o_fir_en     (o_fir_en),
    .o_update_en  (o_update_en),
    .o_mu         (o_mu),
    .o_dd_mode    (o_dd_mode),
    .o_locked     (o_locked),
    .o_state      (o_state),
    .o_win_metric (o_win_metric)
  );

  always #5 i_clock = ~i_clock;

  function automatic obs_t dut_obs();
    return {o_fir_en, o_update_en, o_mu, o_dd_mode,
            o_locked, o_state, o_win_metric};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.fir = (m_st != 0);
    o.upd = m_upd;
    o.mu  = 16'(m_mu);
    o.dd  = m_dd;
    o.lk  = m_lk;
    o.st  = 2'(m_st);
    o.met = 14'(m_met);
    return o;
  endfunction

  function automatic void m_clear(bit keep_metric);
    m_st = 0; m_fill = 0; m_dec = 0; m_lock = 0; m_ann = 0;
    m_mu = 0; m_sum = 0; m_n = 0; m_upd = 0; m_dd = 0; m_lk = 0;
    if (!keep_metric) m_met = 0;
  endfunction

  // Outputs after one clock, given this cycle's inputs.
  function automatic void m_step(bit st, bit sp, bit f, bit v, int e,
                                 int lthr, int uthr);
    int a;
    m_upd = 0;
    if (sp) begin
      m_clear(1);
      return;
    end
    if (m_st == 0) begin
      if (st) m_st = 1;
      return;
    end
    if (!v) return;
    if (m_st == 1) begin
      m_fill++;
      if (m_fill == FILL_N) begin
        m_st = 2; m_fill = 0; m_mu = MU_INIT;
      end
      return;
    end
    m_dec = (m_dec + 1) % UPD_DEC;
    if (m_dec == 0 && !f) m_upd = 1;
    a = (e < 0) ? -e : e;
    if (a > 127) a = 127;
    m_sum += a;
    m_n++;
    if (m_n < WIN_N) return;
    m_met = m_sum; m_sum = 0; m_n = 0;
    if (m_st == 2) begin
      m_lock = (m_met < lthr) ? m_lock + 1 : 0;
      if (m_lock == LOCK_CNT) begin
        m_st = 3; m_mu = MU_TRACK; m_lk = 1; m_dd = 1;
        m_lock = 0; m_ann = 0;
      end else if (!f) begin
        m_ann++;
        if (m_ann == ANNEAL_WIN) begin
          m_ann = 0;
          m_mu = (m_mu / 2 < MU_MIN) ? MU_MIN : m_mu / 2;
        end
      end
    end else if (m_met > uthr) begin
      m_st = 2; m_mu = MU_INIT; m_lk = 0; m_dd = 0;
      m_lock = 0; m_ann = 0;
    end
  endfunction

  task automatic tick(bit st, bit sp, bit f, bit v, int e);
    @(negedge i_clock);
    i_start = st; i_stop = sp; i_freeze = f; i_valid = v;
    i_cma_error = 8'(e);
    m_step(st, sp, f, v, e, int'(i_lock_thr), int'(i_unlock_thr));
    exp_q.push_back(model_obs());
  endtask

  task automatic run(int n, int vpct, int elo, int ehi, bit f);
    for (int i = 0; i < n; i++)
      tick(0, 0, f, $urandom_range(99) < vpct,
           elo + int'($urandom_range(ehi - elo)));
  endtask

  task automatic do_reset();
    obs_t got;
    @(negedge i_clock);
    i_reset = 1'b1; i_start = 0; i_stop = 0; i_valid = 1'b1;
    #1;
    got = dut_obs();
    n_checks++;
    if (got != '0) begin
      n_errors++;
      $display("FAIL reset_async: got %h want 0", got);
    end
    m_clear(0);
    exp_q.push_back(model_obs());
    @(negedge i_clock);
    i_reset = 1'b0; i_valid = 1'b0;
    m_step(0, 0, 0, 0, 0, int'(i_lock_thr), int'(i_unlock_thr));
    exp_q.push_back(model_obs());
  endtask

  initial begin : monitor
    obs_t e, g;
    forever begin
      @(posedge i_clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = dut_obs();
        n_checks++;
        if (g !== e) begin
          n_errors++;
          $display("FAIL cycle_out t=%0t: got fir=%b upd=%b mu=%h dd=%b lk=%b st=%0d met=%0d want fir=%b upd=%b mu=%h dd=%b lk=%b st=%0d met=%0d",
                   $time, g.fir, g.upd, g.mu, g.dd, g.lk, g.st, g.met,
                   e.fir, e.upd, e.mu, e.dd, e.lk, e.st, e.met);
        end
      end
    end
  end

  initial begin : stim
    m_clear(0);
    do_reset();
    run(6, 60, -128, 127, 0);
    tick(1, 0, 0, 1, 1);
    run(23 + 300, 100, 1, 1, 0);
    run(400, 70, -20, 20, 0);
    run(80, 100, -128, -128, 0);
    run(300, 100, 50, 50, 0);
    tick(1, 0, 0, 1, 50);
    run(300, 100, 50, 50, 1);
    run(500, 100, 50, 50, 0);
    run(128, 100, 50, 50, 1);
    run(2200, 100, 45, 55, 0);
    run(150, 90, 40, 60, 1);
    for (int i = 0; i < 200; i++)
      tick(0, 0, $urandom_range(3) == 0, $urandom_range(9) < 8,
           int'($urandom_range(120)) - 60);
    run(500, 80, -1, 1, 0);
    run(30, 100, -1, 1, 0);
    tick(0, 1, 0, 1, 5);
    run(10, 50, -128, 127, 0);
    tick(1, 0, 0, 0, 0);
    run(23 + 100, 100, -3, 3, 0);
    do_reset();
    run(5, 100, 2, 2, 0);
    @(negedge i_clock);
    @(negedge i_clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ffe_adapt_ctrl.md
Name: ffe_adapt_ctrl

Overview:
Adaptation sequencer for the FFE + CMA equalizer. It gates the FIR enable and the coefficient-update enable, and schedules the step size mu through acquisition annealing and a tracking value. It monitors a windowed |CMA error| metric to declare lock and switch the slicer to decision-directed mode. It sits beside the FIR/CMA datapath and drives its i_en, i_update_en and mu inputs.

Parameters:
FIR_LEN, 21, FFE taps; sets fill length
PIPE_LAT, 2, sample-to-slicer latency in valid samples
NB_ERR, 8, CMA error width (signed)
NB_MU, 16, step-size width (unsigned)
MU_INIT, 16'h4000, acquisition start mu
MU_MIN, 16'h0400, annealing floor
MU_TRACK, 16'h0200, tracking mu
UPD_DEC, 1, one update per UPD_DEC valid samples
WIN_LOG2, 6, metric window = 2^WIN_LOG2 valid samples
LOCK_CNT, 4, consecutive good windows required to lock
ANNEAL_WIN, 8, windows between mu halvings
NB_ACC, NB_ERR+WIN_LOG2, metric width (derived, localparam)

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  pulse; leaves IDLE
i_stop  in  1  pulse; returns to IDLE from any state
i_freeze  in  1  level; suppresses coefficient updates
i_valid  in  1  sample strobe, aligned with i_cma_error
i_cma_error  in  NB_ERR  signed CMA error of current slicer sample
i_lock_thr  in  NB_ACC  lock threshold on window metric
i_unlock_thr  in  NB_ACC  unlock threshold on window metric
o_fir_en  out  1  FIR/CMA enable
o_update_en  out  1  one-cycle coefficient-update pulse
o_mu  out  NB_MU  current step size
o_dd_mode  out  1  0 = CMA error, 1 = decision-directed
o_locked  out  1  lock flag
o_state  out  2  IDLE=0, FILL=1, ACQ=2, TRACK=3
o_win_metric  out  NB_ACC  last completed window sum of |err|

Behaviour:
- Reset (async, active-high): state IDLE; every output and every internal counter/accumulator = 0.
- All outputs are registered and update on the cycle after the qualifying input.
- IDLE: o_fir_en=0. i_start -> FILL. o_fir_en=1 in FILL/ACQ/TRACK.
- FILL: count i_valid. After FIR_LEN+PIPE_LAT valid samples (23 by default) -> ACQ, mu<=MU_INIT. No update pulses and no metric accumulation in FILL.
- Update pulse (ACQ/TRACK only): on i_valid, the decimation counter advances modulo UPD_DEC. At wrap with i_freeze=0, o_update_en=1 for exactly one cycle. With i_freeze=1, no pulse is issued and the counter still advances.
- Metric: on i_valid in ACQ/TRACK, accumulate |i_cma_error|. |-2^(NB_ERR-1)| saturates to 2^(NB_ERR-1)-1. On the 2^WIN_LOG2-th sample: o_win_metric <= sum including that sample; accumulator cleared.
- ACQ window end:
  - sum < i_lock_thr: lock_cnt++. Otherwise lock_cnt=0.
  - lock_cnt reaches LOCK_CNT: -> TRACK; mu<=MU_TRACK, o_locked=1, o_dd_mode=1.
  - Otherwise, with i_freeze=0, the anneal counter increments. Every ANNEAL_WIN windows, mu <= max(mu>>1, MU_MIN). With i_freeze=1 the anneal counter holds.
- TRACK window end: sum > i_unlock_thr -> ACQ. mu<=MU_INIT; o_locked, o_dd_mode, lock_cnt and anneal counter cleared.
- Priority: i_reset > i_stop > window-end transition > i_start.
- i_stop: next cycle IDLE. All outputs return to reset values except o_win_metric, which holds. Counters and accumulator are cleared.
- i_start outside IDLE is ignored. i_valid in IDLE is ignored.
- Lock evaluation continues during i_freeze. An in-progress window completes across freeze.

Decomposition:
- Package ffe_adapt_pkg: state encoding localparams and an abs-with-saturation function parameterized by NB_ERR.
- One sub-module, err_win_acc: abs, accumulate, window counter, and o_win_metric register with a window-done pulse. The FSM, mu scheduler and update decimator stay in ffe_adapt_ctrl.

Test Plan:
1. Start/fill: reset, i_start, i_valid=1 continuously. o_fir_en=1 one cycle after start; o_state=1 for 23 samples; o_mu=16'h4000 and first o_update_en on the cycle after sample 24.
2. Lock: i_cma_error=1, i_lock_thr=100. Windows sum to 64. After 4 windows (256 ACQ samples): o_state=3, o_mu=16'h0200, o_locked=1, o_dd_mode=1.
3. Anneal: i_cma_error=50, i_lock_thr=100 (sum 3200). o_mu steps 0x2000/0x1000/0x0800/0x0400 every 512 valid samples, then holds 0x0400. A freeze over one anneal interval delays the step by the frozen windows.
4. Unlock/saturation: in TRACK, i_cma_error=-128, i_unlock_thr=2000. o_win_metric=8128 (127*64) -> ACQ; o_mu=16'h4000, o_locked=0.
5. Freeze: i_freeze=1 in ACQ for 100 valid samples -> zero o_update_en pulses. Metric is still updated; pulses resume on the next valid after release.
6. Stop/reset mid-op: i_stop in TRACK mid-window -> IDLE next cycle, o_win_metric held. i_reset mid-window -> all outputs 0 immediately, without a clock edge.
